// File: rtl/sa_drain_buf.sv
// sa_drain_buf: systolic-array readout stage.
// Snapshots the PE result grid on a capture pulse and streams it out one row per beat
// under a valid/ready handshake. Optional macro SA_DRAIN_PINGPONG_EN adds a second
// shadow bank so a tile captured mid-drain is queued instead of dropped.
module sa_drain_buf #(
    parameter int unsigned ROWS     = 16,
    parameter int unsigned COLS     = 16,
    parameter int unsigned PIX88_W  = 24,
    parameter int unsigned PIX18_W  = 16,
    parameter int unsigned PE_OUT_W = 4 * PIX18_W,
    parameter int unsigned ROW_W    = $clog2(ROWS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mode,
    input  logic                           capture,
    input  logic [ROWS*COLS*PE_OUT_W-1:0]  pe_out,
    input  logic [ROW_W-1:0]               rows_active,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COLS*PE_OUT_W-1:0]       out_data,
    output logic [ROW_W-1:0]               out_row,
    output logic                           out_last,
    output logic                           busy,
    output logic                           capture_drop
);

    localparam int unsigned ROW_BITS = COLS * PE_OUT_W;
    localparam int unsigned LANE88   = 2 * PIX88_W;
    localparam int unsigned LANE18   = 2 * PIX18_W;
    localparam int unsigned IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] ONE      = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROWS_CNT = ROW_W'(ROWS);

    typedef logic [ROW_BITS-1:0] row_t;
    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    // Repack one row of PE results into the beat layout for the given mode.
    function automatic row_t pack_row(input row_t row, input logic m);
        row_t o;
        o = '0;
        for (int j = 0; j < COLS; j++) begin
            if (!m) begin
                o[j*LANE88 +: LANE88] = row[j*PE_OUT_W +: LANE88];
            end else begin
                o[j*LANE18 +: LANE18]               = row[j*PE_OUT_W +: LANE18];
                o[COLS*LANE18 + j*LANE18 +: LANE18] = row[j*PE_OUT_W + LANE18 +: LANE18];
            end
        end
        return o;
    endfunction

    // Zero or out-of-range row counts mean "whole array".
    function automatic logic [ROW_W-1:0] eff_rows(input logic [ROW_W-1:0] ra);
        if (ra == '0 || ra > ROWS_CNT) begin
            return ROWS_CNT;
        end
        return ra;
    endfunction

    state_e           state_q;
    row_t             shadow_q [ROWS];
    logic             mode_q;
    logic [ROW_W-1:0] n_q;

    logic             fire;
    logic             final_fire;
    logic             start_cap;
    logic             start_pend;
    logic             drop;
    logic [ROW_W-1:0] cap_n;
    logic [ROW_W-1:0] next_row;
    logic [IDX_W-1:0] adv_idx;
    row_t             adv_beat;
    row_t             cap_beat;

`ifdef SA_DRAIN_PINGPONG_EN
    row_t             pend_bank_q [ROWS];
    logic             pend_q;
    logic             pend_mode_q;
    logic [ROW_W-1:0] pend_n_q;
    logic             load_pend;
    row_t             pend_beat;
`endif

    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q == StDrain);

    // Handshake decode and candidate next beats (row 0 of a new tile comes straight from
    // the capture source so the first beat is ready one cycle after capture).
    always_comb begin
        fire       = (state_q == StDrain) && out_ready;
        final_fire = fire && out_last;
        cap_n      = eff_rows(rows_active);
        next_row   = out_row + ONE;
        adv_idx    = next_row[IDX_W-1:0];
        adv_beat   = pack_row(shadow_q[adv_idx], mode_q);
        cap_beat   = pack_row(pe_out[ROW_BITS-1:0], mode);
`ifdef SA_DRAIN_PINGPONG_EN
        pend_beat  = pack_row(pend_bank_q[0], pend_mode_q);
        start_pend = final_fire && pend_q;
        start_cap  = capture && ((state_q == StIdle) || (final_fire && !pend_q));
        // A capture landing as the queued tile is promoted refills the freed pending bank.
        load_pend  = capture && (state_q == StDrain) && !start_cap && (!pend_q || start_pend);
        drop       = capture && (state_q == StDrain) && !start_cap && !load_pend;
`else
        start_pend = 1'b0;
        start_cap  = capture && ((state_q == StIdle) || final_fire);
        drop       = capture && !start_cap;
`endif
    end

    // Shadow bank(s): snapshot of the PE grid, deliberately not reset.
    always_ff @(posedge clk) begin
        if (start_cap) begin
            for (int r = 0; r < ROWS; r++) begin
                shadow_q[r] <= pe_out[r*ROW_BITS +: ROW_BITS];
            end
        end
`ifdef SA_DRAIN_PINGPONG_EN
        else if (start_pend) begin
            for (int r = 0; r < ROWS; r++) begin
                shadow_q[r] <= pend_bank_q[r];
            end
        end
        if (load_pend) begin
            for (int r = 0; r < ROWS; r++) begin
                pend_bank_q[r] <= pe_out[r*ROW_BITS +: ROW_BITS];
            end
        end
`endif
    end

    // Drain FSM with registered beat outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            n_q          <= '0;
            out_data     <= '0;
            out_row      <= '0;
            out_last     <= 1'b0;
            capture_drop <= 1'b0;
`ifdef SA_DRAIN_PINGPONG_EN
            pend_q       <= 1'b0;
            pend_mode_q  <= 1'b0;
            pend_n_q     <= '0;
`endif
        end else begin
            capture_drop <= drop;
            if (start_cap) begin
                state_q  <= StDrain;
                mode_q   <= mode;
                n_q      <= cap_n;
                out_row  <= '0;
                out_data <= cap_beat;
                out_last <= (cap_n == ONE);
            end
`ifdef SA_DRAIN_PINGPONG_EN
            else if (start_pend) begin
                state_q  <= StDrain;
                mode_q   <= pend_mode_q;
                n_q      <= pend_n_q;
                out_row  <= '0;
                out_data <= pend_beat;
                out_last <= (pend_n_q == ONE);
            end
`endif
            else if (final_fire) begin
                state_q  <= StIdle;
                out_last <= 1'b0;
            end else if (fire) begin
                out_row  <= next_row;
                out_data <= adv_beat;
                out_last <= (next_row == n_q - ONE);
            end
`ifdef SA_DRAIN_PINGPONG_EN
            if (load_pend) begin
                pend_q      <= 1'b1;
                pend_mode_q <= mode;
                pend_n_q    <= cap_n;
            end else if (start_pend) begin
                pend_q      <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sa_drain_buf.sv
// Directed testbench for sa_drain_buf (default 16x16 configuration).
module tb_sa_drain_buf;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int PEW  = 64;
    localparam int RW   = 5;
    localparam int DW   = COLS * PEW;

    logic                     clk;
    logic                     reset;
    logic                     mode;
    logic                     capture;
    logic [ROWS*COLS*PEW-1:0] pe_out;
    logic [RW-1:0]            rows_active;
    logic                     out_valid;
    logic                     out_ready;
    logic [DW-1:0]            out_data;
    logic [RW-1:0]            out_row;
    logic                     out_last;
    logic                     busy;
    logic                     capture_drop;

    int total = 0;
    int bad   = 0;

    sa_drain_buf #(
        .ROWS    (16),
        .COLS    (16),
        .PIX88_W (24),
        .PIX18_W (16),
        .PE_OUT_W(64),
        .ROW_W   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .capture     (capture),
        .pe_out      (pe_out),
        .rows_active (rows_active),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .capture_drop(capture_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit tag identifying tile t, row r, column c.
    function automatic logic [15:0] h(input int t, input int r, input int c);
        logic [15:0] v;
        v = {4'(t), 4'(r), 8'(c)};
        return v;
    endfunction

    function automatic logic [DW-1:0] beat_exp(input int t, input int r, input logic m);
        logic [DW-1:0] b;
        logic [15:0]   v;
        b = '0;
        for (int j = 0; j < COLS; j++) begin
            v = h(t, r, j);
            if (!m) begin
                b[j*48 +: 48] = {3{v}};
            end else begin
                b[j*32 +: 32]       = {2{v}};
                b[512 + j*32 +: 32] = {2{v}};
            end
        end
        return b;
    endfunction

    task automatic load_pe(input int t);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pe_out[(r*COLS+c)*PEW +: PEW] = {4{h(t, r, c)}};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int k;
        total++;
        assert (obs === exp) else begin
            bad++;
            k = 0;
            for (int i = COLS - 1; i >= 0; i--)
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) k = i;
            $error("FAIL %s chunk%0d observed=%h expected=%h", tag, k, obs[k*64 +: 64],
                   exp[k*64 +: 64]);
        end
    endtask

    task automatic cap(input int t, input logic m, input int ra);
        load_pe(t);
        mode        = m;
        rows_active = RW'(ra);
        capture     = 1'b1;
        step();
        capture     = 1'b0;
        load_pe(15);
    endtask

    // Follow one tile to its end; every displayed beat is compared with the model.
    task automatic drain(input int t, input logic m, input int n, input bit rnd);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 200) begin
            chk($sformatf("valid t%0d r%0d", t, got), 64'(out_valid), 64'd1);
            chk($sformatf("busy t%0d r%0d", t, got), 64'(busy), 64'd1);
            chk($sformatf("row t%0d", t), 64'(out_row), 64'(got));
            chk($sformatf("last t%0d r%0d", t, got), 64'(out_last), 64'(got == n - 1));
            chk_beat($sformatf("data t%0d r%0d", t, got), out_data, beat_exp(t, got, m));
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (out_ready) got++;
            cyc++;
        end
        chk($sformatf("beats t%0d", t), 64'(got), 64'(n));
        out_ready = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        mode        = 1'b0;
        capture     = 1'b0;
        rows_active = '0;
        out_ready   = 1'b1;
        pe_out      = '0;
        step();
        step();
        chk("rst valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst last", 64'(out_last), 64'd0);
        chk("rst drop", 64'(capture_drop), 64'd0);
        chk("rst row", 64'(out_row), 64'd0);
        chk_beat("rst data", out_data, '0);
        reset = 1'b0;
        step();
        chk("idle valid", 64'(out_valid), 64'd0);

        // Full tile, mode 0, continuous ready; pe_out scrambled after capture.
        cap(0, 1'b0, 16);
        drain(0, 1'b0, 16, 1'b0);
        chk("t0 end valid", 64'(out_valid), 64'd0);
        chk("t0 end busy", 64'(busy), 64'd0);

        // Mode 1 with 4 active rows and one distinctive PE.
        load_pe(1);
        pe_out[(2*COLS+3)*PEW +: PEW] = 64'hAAAA_BBBB_CCCC_DDDD;
        mode        = 1'b1;
        rows_active = 5'd4;
        capture     = 1'b1;
        step();
        capture = 1'b0;
        load_pe(15);
        chk("m1 row0", 64'(out_row), 64'd0);
        chk("m1 last0", 64'(out_last), 64'd0);
        step();
        chk("m1 row1", 64'(out_row), 64'd1);
        step();
        chk("m1 row2", 64'(out_row), 64'd2);
        chk("m1 lane3 lo", 64'(out_data[3*32 +: 32]), 64'hCCCC_DDDD);
        chk("m1 lane3 hi", 64'(out_data[512 + 3*32 +: 32]), 64'hAAAA_BBBB);
        chk("m1 lane0 lo", 64'(out_data[0 +: 32]), 64'h1200_1200);
        chk("m1 last2", 64'(out_last), 64'd0);
        step();
        chk("m1 row3", 64'(out_row), 64'd3);
        chk("m1 last3", 64'(out_last), 64'd1);
        step();
        chk("m1 end valid", 64'(out_valid), 64'd0);

        // Random backpressure.
        cap(2, 1'b0, 16);
        drain(2, 1'b0, 16, 1'b1);
        chk("t2 end valid", 64'(out_valid), 64'd0);

        // Capture while draining at row 5 (and again at row 8).
        cap(3, 1'b0, 16);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("mid row%0d", r), 64'(out_row), 64'(r));
            chk_beat($sformatf("mid data r%0d", r), out_data, beat_exp(3, r, 1'b0));
`ifdef SA_DRAIN_PINGPONG_EN
            if (r == 6) chk("mid drop r6", 64'(capture_drop), 64'd0);
            if (r == 9) chk("mid drop r9", 64'(capture_drop), 64'd1);
            if (r == 10) chk("mid drop r10", 64'(capture_drop), 64'd0);
`else
            if (r == 6) chk("mid drop r6", 64'(capture_drop), 64'd1);
            if (r == 7) chk("mid drop r7", 64'(capture_drop), 64'd0);
`endif
            if (r == 5) load_pe(4);
            if (r == 8) load_pe(5);
            if (r == 6 || r == 9) load_pe(15);
            capture = (r == 5 || r == 8);
            step();
        end
        capture = 1'b0;
`ifdef SA_DRAIN_PINGPONG_EN
        drain(4, 1'b0, 16, 1'b0);
`endif
        chk("mid end valid", 64'(out_valid), 64'd0);

        // Capture coincident with the final transfer: no idle gap.
        cap(6, 1'b0, 3);
        chk("b2b row0", 64'(out_row), 64'd0);
        step();
        chk("b2b row1", 64'(out_row), 64'd1);
        step();
        chk("b2b row2", 64'(out_row), 64'd2);
        chk("b2b last2", 64'(out_last), 64'd1);
        load_pe(7);
        mode        = 1'b1;
        rows_active = 5'd2;
        capture     = 1'b1;
        step();
        capture = 1'b0;
        load_pe(15);
        drain(7, 1'b1, 2, 1'b0);
        chk("b2b end valid", 64'(out_valid), 64'd0);

        // Out-of-range row counts; later input changes ignored by the running tile.
        cap(10, 1'b0, 0);
        rows_active = 5'd3;
        mode        = 1'b1;
        drain(10, 1'b0, 16, 1'b0);
        chk("ra0 end valid", 64'(out_valid), 64'd0);
        cap(11, 1'b0, 20);
        drain(11, 1'b0, 16, 1'b0);
        chk("ra20 end valid", 64'(out_valid), 64'd0);

        // Reset mid-drain at row 7.
        cap(12, 1'b0, 16);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("rst-mid row%0d", r), 64'(out_row), 64'(r));
            if (r == 7) reset = 1'b1;
            step();
        end
        chk("rst-mid valid", 64'(out_valid), 64'd0);
        chk("rst-mid busy", 64'(busy), 64'd0);
        chk("rst-mid row", 64'(out_row), 64'd0);
        reset = 1'b0;
        step();
        step();
        chk("rst-mid stay idle", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
